// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg
//   Shared definitions for the instruction fetch front end:
//   - fetch_state_e : fetch controller state encoding (IDLE, RUN, FAULT)
//   - RESET_PC_DEFAULT / ADDR_W_DEFAULT : default top-level parameter values
//   - fetch_entry_t : packed {pc, instr} entry carried by the fetch buffer
//   - is_word_aligned() : byte address has bits [1:0] == 0
package cpu_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          ADDR_W_DEFAULT   = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   DEPTH-entry synchronous FIFO of fetch_entry_t between the BRAM response
//   and decode. Flush has priority over push and pop in the same cycle.
//   The head output is forced to zero while empty so the downstream payload
//   is deterministic when nothing is valid.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        discard all entries
//   push_i         write push_data_i (ignored when full and not popping)
//   push_data_i    entry to write
//   pop_i          remove head (ignored when empty)
//   head_o         current head entry (zero when empty)
//   empty_o        no entries held
//   count_o        number of entries held, 0..DEPTH
module fetch_buffer
   import cpu_fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   rd_q;
   logic [PW-1:0]   wr_q;
   logic [CW-1:0]   cnt_q;
   logic            full;
   logic            do_push;
   logic            do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full | do_pop);
   assign count_o = cnt_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= ptr_inc(wr_q);
         if (do_pop)  rd_q <= ptr_inc(rd_q);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: reads are gated by the count.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   CPU fetch front end. Owns the PC, drives the instruction BRAM word
//   address every cycle, absorbs the BRAM's one-cycle read latency and hands
//   {pc, instr} to decode over valid/ready. Handles redirects from execute,
//   run/stop from the control path and misaligned-target faults.
//
//   Optional build macro IFETCH_RANGE_CHECK_EN: when defined, a PC about to
//   issue with any bit set above the BRAM window ([31:ADDR_W+2]) is not
//   issued and raises the fault instead. When undefined, addresses simply
//   alias modulo the BRAM size.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_en                   run enable; 0 stops issuing new fetches
//   imem_addr      [ADDR_W]    BRAM word address (combinational)
//   imem_rdata     [32]        BRAM data for the previous cycle's address
//   redirect_valid/redirect_pc single-cycle redirect from execute
//   out_valid/out_ready        handshake to decode
//   out_pc/out_instr           byte PC and instruction at the buffer head
//   fault/fault_pc             sticky bad-target fault and offending address
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | stopped, no fetches issued; enters RUN when fetch_en=1
// RUN    | issuing one fetch per cycle while buffer space allows
// FAULT  | bad target seen; waits for reset or an aligned redirect
module instr_fetch_unit
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          ADDR_W    = ADDR_W_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic              fault,
   output logic [31:0]       fault_pc
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          fault_q, fault_d;
   logic [31:0]   fault_pc_q, fault_pc_d;

   logic          redir_ok;
   logic          redir_bad;
   logic [31:0]   pres_pc;
   logic          run_ok;
   logic          space_ok;
   logic          range_bad;
   logic          issue;
   logic          pop;
   logic          push;
   logic [CW:0]   occ_next;
   logic [CW-1:0] buf_count;
   logic          buf_empty;
   fetch_entry_t  buf_head;
   fetch_entry_t  push_entry;

   assign redir_ok  = redirect_valid &  is_word_aligned(redirect_pc);
   assign redir_bad = redirect_valid & ~is_word_aligned(redirect_pc);

   // The redirect target bypasses the PC register so it is fetched the same
   // cycle the redirect arrives.
   assign pres_pc   = redirect_valid ? redirect_pc : fetch_pc_q;
   assign imem_addr = pres_pc[ADDR_W+1:2];

   assign out_valid = ~buf_empty;
   assign out_pc    = buf_head.pc;
   assign out_instr = buf_head.instr;
   assign pop       = out_valid & out_ready;

   // Issue needs RUN now, or an aligned redirect that lands in RUN.
   assign run_ok = fetch_en & (redir_ok | (~redirect_valid & (state_q == ST_RUN)));

   // Entries that will occupy the buffer once the in-flight word lands.
   // A redirect flushes everything, so the target always has room.
   assign occ_next = (CW+1)'(buf_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign space_ok = redirect_valid | (occ_next < (CW+1)'(BUF_DEPTH));

`ifdef IFETCH_RANGE_CHECK_EN
   assign range_bad = run_ok & space_ok & (pres_pc[31:ADDR_W+2] != '0);
`else
   assign range_bad = 1'b0;
`endif

   assign issue = run_ok & space_ok & ~range_bad;

   // A redirect in the response cycle kills the stale in-flight word.
   assign push       = inflight_q & ~redirect_valid;
   assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

   always_comb begin
      state_d    = state_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      if (redir_bad) begin
         state_d    = ST_FAULT;
         fault_d    = 1'b1;
         fault_pc_d = redirect_pc;
      end else if (range_bad) begin
         state_d    = ST_FAULT;
         fault_d    = 1'b1;
         fault_pc_d = pres_pc;
      end else if (redir_ok) begin
         state_d = fetch_en ? ST_RUN : ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  if (fetch_en)  state_d = ST_RUN;
            ST_RUN:   if (!fetch_en) state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (issue) begin
         fetch_pc_d    = pres_pc + 32'd4;
         inflight_pc_d = pres_pc;
      end else if (redir_ok) begin
         // Keep the target even when not running, so a later enable starts there.
         fetch_pc_d = redirect_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         fault_q       <= 1'b0;
         fault_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fault_q       <= fault_d;
         fault_pc_q    <= fault_pc_d;
      end
   end

   assign fault    = fault_q;
   assign fault_pc = fault_pc_q;

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (buf_head),
      .empty_o     (buf_empty),
      .count_o     (buf_count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic [11:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        fault;
   logic [31:0] fault_pc;

   always #5 clk = ~clk;

   // BRAM model: registered read, one cycle latency.
   logic [31:0] mem [4096];
   always @(posedge clk) imem_rdata <= mem[imem_addr];

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .fault          (fault),
      .fault_pc       (fault_pc)
   );

   int          checks   = 0;
   int          failures = 0;

   // Reference model: accepted instructions form a sequential PC stream
   // starting at the last redirect target (or reset PC), each carrying the
   // BRAM word at pc/4 modulo the BRAM size.
   logic [31:0] exp_pc;
   bit          mon_en;
   int          n_acc;
   logic [31:0] last_acc_instr;
   bit          hold_prev;
   logic [31:0] hold_pc, hold_instr;
   logic [11:0] last_addr;
   logic        last_valid;

   function automatic logic [31:0] ref_instr(input logic [31:0] pc);
      return mem[pc[13:2]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Sample just after inputs settle, run the stream monitor, then advance
   // to 1 time unit past the next rising edge.
   task automatic cycle();
      #1;
      last_addr  = imem_addr;
      last_valid = out_valid;
      if (mon_en) begin
         if (hold_prev) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, hold_pc);
            chk("hold_instr", out_instr, hold_instr);
         end
         if (out_valid && out_ready) begin
            chk("stream_pc", out_pc, exp_pc);
            chk("stream_instr", out_instr, ref_instr(exp_pc));
            last_acc_instr = out_instr;
            exp_pc += 32'd4;
            n_acc++;
         end
         hold_prev  = out_valid && !out_ready && !redirect_valid;
         hold_pc    = out_pc;
         hold_instr = out_instr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      cycle();
      redirect_valid = 1'b0;
      if (target[1:0] == 2'b00) exp_pc = target;
   endtask

   task automatic wait_accept(input string tag);
      int n0;
      int t;
      n0 = n_acc;
      t  = 0;
      while (n_acc == n0 && t < 30) begin
         cycle();
         t++;
      end
      chk(tag, {31'd0, n_acc > n0}, 32'd1);
   endtask

   logic [11:0] addr_log [6];
   logic        vld_log  [6];

   initial begin
      int first_v;
      int n0;
      for (int i = 0; i < 4096; i++) mem[i] = (i < 4) ? 32'h0000_0013 + 32'(i) : $urandom;
      rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      out_ready = 1'b0; mon_en = 1'b0; n_acc = 0; hold_prev = 1'b0; exp_pc = '0;
      last_acc_instr = '0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_fault_pc", fault_pc, 32'd0);
      chk("rst_imem_addr", {20'd0, imem_addr}, 32'd0);

      // Start-up latency and sequential stream.
      @(posedge clk); #1;
      rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1; mon_en = 1'b1; exp_pc = 32'd0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         addr_log[i] = last_addr;
         vld_log[i]  = last_valid;
      end
      for (int i = 1; i <= 4; i++) chk("startup_addr", {20'd0, addr_log[i]}, 32'(i - 1));
      first_v = -1;
      for (int i = 5; i >= 0; i--) if (vld_log[i]) first_v = i;
      chk("first_valid_cycle", 32'(first_v), 32'd3);
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("no_bubble", {31'd0, last_valid}, 32'd1);
      end

      // Backpressure.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("bp_occupancy", 32'(dut.u_buf.count_o), 32'd2);
      chk("bp_no_inflight", {31'd0, dut.inflight_q}, 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cycle();

      // Redirect with data buffered and a fetch in flight.
      chk("pre_redir_inflight", {31'd0, dut.inflight_q}, 32'd1);
      do_redirect(32'h0000_0100);
      chk("redir_addr", {20'd0, last_addr}, 32'h40);
      chk("redir_flush", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      wait_accept("redir_resume");
      for (int i = 0; i < 4; i++) cycle();

      // Misaligned redirect, then recovery with an aligned one.
      do_redirect(32'h0000_0102);
      out_ready = 1'b1;
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_fault_pc", fault_pc, 32'h102);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("fault_quiet", {31'd0, last_valid}, 32'd0);
      end
      do_redirect(32'h0000_0200);
      out_ready = 1'b1;
      wait_accept("fault_resume");
      chk("fault_sticky", {31'd0, fault}, 32'd1);

      // fetch_en gap right after issuing PC 0x10.
      do_redirect(32'h0000_0000);
      out_ready = 1'b1;
      begin
         int t;
         t = 0;
         last_addr = '0;
         while (t < 30) begin
            cycle();
            t++;
            if (last_addr == 12'd4) break;
         end
         chk("reach_pc10", {20'd0, last_addr}, 32'd4);
      end
      fetch_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("gap_no_issue", {20'd0, last_addr}, 32'd5);
      end
      chk("gap_drained", exp_pc, 32'h14);
      fetch_en = 1'b1;
      wait_accept("gap_resume");

      // Randomized traffic.
      n0 = n_acc;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            do_redirect(32'($urandom_range(0, 1023)) << 2);
         end else begin
            out_ready = ($urandom_range(0, 3) != 0);
            fetch_en  = ($urandom_range(0, 7) != 0);
            cycle();
         end
      end
      fetch_en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      chk("rand_progress", {31'd0, n_acc > n0 + 50}, 32'd1);

      // Target above the BRAM window.
      do_redirect(32'h0000_4000);
      out_ready = 1'b1;
`ifdef IFETCH_RANGE_CHECK_EN
      chk("range_fault", {31'd0, fault}, 32'd1);
      chk("range_fault_pc", fault_pc, 32'h4000);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("range_quiet", {31'd0, last_valid}, 32'd0);
      end
`else
      wait_accept("alias_fetch");
      chk("alias_instr", last_acc_instr, 32'h0000_0013);
`endif

      // Reset in the middle of streaming.
      do_redirect(32'h0000_0020);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_fault", {31'd0, fault}, 32'd0);
      chk("mid_rst_fault_pc", fault_pc, 32'd0);
      chk("mid_rst_out_pc", out_pc, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; exp_pc = 32'd0; hold_prev = 1'b0; mon_en = 1'b1;
      wait_accept("post_rst_resume");
      for (int i = 0; i < 4; i++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the CPU core, directly upstream of the instruction BRAM. Owns the PC, drives the BRAM word address every cycle, absorbs the BRAM's 1-cycle registered read latency, and hands {pc, instr} to decode over a valid/ready handshake. Handles branch/jump redirects from execute, run/stop from the AXI control path, and misaligned-target faults.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
ADDR_W, 12, BRAM word-address width (4096 words = 16KB).
BUF_DEPTH, 2, instruction buffer entries; minimum 2 for full throughput.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  run enable from AXI control; 0 = stop issuing fetches
imem_addr  out  ADDR_W  BRAM word address; combinational
imem_rdata  in  32  BRAM data for the address presented on the previous cycle
redirect_valid  in  1  single-cycle redirect from execute
redirect_pc  in  32  redirect target byte address
out_valid  out  1  {out_pc, out_instr} valid to decode
out_ready  in  1  decode accepts this cycle
out_pc  out  32  byte PC of out_instr
out_instr  out  32  fetched instruction
fault  out  1  sticky misaligned-target fault
fault_pc  out  32  offending target address

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC; buffer empty; in-flight flag clear; out_valid=0, out_pc=0, out_instr=0; fault=0, fault_pc=0; state IDLE.
- States:
  - IDLE: no issue. Go to RUN when fetch_en=1.
  - RUN: issue per the rules below. Go to IDLE when fetch_en=0; go to FAULT on a misaligned redirect.
  - FAULT: no issue. Leave only on reset or an aligned redirect, which goes to RUN if fetch_en=1, else IDLE.
- imem_addr:
  - redirect_valid=1: redirect_pc[ADDR_W+1:2].
  - Otherwise: fetch_pc[ADDR_W+1:2].
  - Always driven; BRAM reads every cycle.
- Issue condition: state RUN (or a redirect producing RUN this cycle) AND (occupancy + inflight − pop) < BUF_DEPTH, where pop = out_valid & out_ready.
  - On issue: inflight_pc <= presented PC; inflight <= 1; fetch_pc <= presented PC + 4.
  - On no issue: inflight <= 0.
- Response: in the cycle after an issue, imem_rdata is pushed with inflight_pc, unless killed by a redirect that cycle.
- Latency: address presented in cycle T gives out_valid in cycle T+2. Steady state with out_ready=1 sustains one instruction per cycle, with no bubbles after the first.
- Output:
  - Buffer head drives out_*; out_valid = buffer non-empty.
  - Payload stays stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle are legal.
- Redirect (redirect_valid=1, redirect_pc[1:0]=0):
  - Flush the buffer, kill the in-flight response, out_valid=0 next cycle.
  - Target is issued in the same cycle.
  - Redirect takes priority over fetch_en=0 for the PC update; issue still requires RUN.
- Misaligned redirect (redirect_pc[1:0]≠0):
  - Flush, kill in-flight, no issue.
  - fault<=1, fault_pc<=redirect_pc; state FAULT.
  - fault stays 1 until reset; a later aligned redirect does not clear it.
- fetch_en falling: the in-flight response still completes into the buffer. Buffered entries remain and drain normally.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC → 0. imem_addr uses only bits [ADDR_W+1:2], so addresses alias every 16KB.
- Reset mid-operation: all state cleared immediately; a stale BRAM response is ignored because inflight=0.

Optional Feature:
IFETCH_RANGE_CHECK_EN
- Defined: any PC about to issue with bits [31:ADDR_W+2] ≠ 0 is not issued. Sets fault/fault_pc as for a misaligned target and enters FAULT.
- Undefined: no range check; addresses alias modulo 16KB as above.

Decomposition:
- Package cpu_fetch_pkg: fetch state enum (IDLE, RUN, FAULT), RESET_PC default, ADDR_W default, packed fetch-entry type {pc[31:0], instr[31:0]}.
- One sub-module: fetch_buffer, a BUF_DEPTH-entry synchronous FIFO with flush, push, pop, and an occupancy count output.

Test Plan:
- Reset, fetch_en=1, out_ready=1, BRAM words 0..3 = 32'h00000013 + n:
  - imem_addr shows 0,1,2,3 on consecutive cycles.
  - out_valid first high 2 cycles after the first issue.
  - out_pc 0,4,8,C on consecutive cycles with matching instr.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream.
  - Occupancy stops at 2; out_pc/out_instr stay stable.
  - On release, PCs continue with no skip or duplicate.
- Redirect to 32'h0000_0100 while buffer full and a fetch in flight:
  - Next cycle out_valid=0.
  - Next accepted instruction has out_pc=0x100; no stale PC ever appears.
- Redirect to 32'h0000_0102:
  - fault=1, fault_pc=0x102, no further issues.
  - Later redirect to 0x200 resumes fetch at 0x200 with fault still 1.
- fetch_en dropped for 3 cycles at PC 0x10:
  - In-flight instruction delivered; no issues during the gap.
  - On re-enable, fetch resumes at the next sequential PC.
- With IFETCH_RANGE_CHECK_EN defined, redirect to 32'h0000_4000 gives fault=1, fault_pc=0x4000. Without the macro, the same redirect fetches BRAM word 0.
